bin_to_seg_formatter: RTL and testbench

- Upstream feeder for the four-digit strobing display driver.
- Accepts an unsigned binary value and a decimal-point select through a start/busy/done handshake.
- Converts the value to four BCD digits with an iterative shift-add-3 (double-dabble) engine, then encodes each digit to an active-low 7-segment byte.
- Holds the four bytes as registered outputs that connect directly to the driver's digitOne..digitFour inputs.

---
 rtl/bin_to_seg_formatter_pkg.sv | 40 ++++
 rtl/bin_to_seg_formatter_encode.sv | 30 +++
 rtl/bin_to_seg_formatter.sv | 136 +++++++++++++
 tb/tb_bin_to_seg_formatter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_seg_formatter_pkg.sv
// Shared constants for the binary-to-7-segment formatter: segment codes,
// decimal-point polarity, FSM states and the double-dabble adjust helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic DP_OFF = 1'b1;

    localparam int unsigned MAX_DISPLAY = 9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        ENCODE
    } state_t;

    // Shift-add-3 step: any nibble of 5 or more would exceed 9 after doubling.
    function automatic logic [15:0] addThree(input logic [15:0] bcd);
        logic [15:0] adj;
        adj = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/bin_to_seg_formatter_encode.sv
// Combinational BCD digit to active-low 7-segment code; blank flag or an
// illegal code (10..15) yields an unlit digit.
import seg7_pkg::*;

module seg7_encode (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin_to_seg_formatter.sv
// Binary value to four registered 7-segment bytes via iterative double-dabble.
// Optional macro LEADING_ZERO_BLANK_EN blanks zeros left of the first non-zero digit.
import seg7_pkg::*;

module bin_to_seg_formatter #(
    parameter int WIDTH = 14
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] VALUE,
    input  logic [3:0]       DP_SEL,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERFLOW,
    output logic [7:0]       digitOne,
    output logic [7:0]       digitTwo,
    output logic [7:0]       digitThree,
    output logic [7:0]       digitFour
);

    localparam logic [4:0] ITER_LAST = 5'(WIDTH - 1);

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] shiftReg;
    logic [15:0]      bcdReg;
    logic [15:0]      bcdAdj;
    logic [4:0]       iterCount;
    logic [3:0]       dpLatch;
    logic             ovfLatch;
    logic             blankOne;
    logic             blankTwo;
    logic             blankThree;
    logic [6:0]       segOne;
    logic [6:0]       segTwo;
    logic [6:0]       segThree;
    logic [6:0]       segFour;
    logic [7:0]       byteOne;
    logic [7:0]       byteTwo;
    logic [7:0]       byteThree;
    logic [7:0]       byteFour;

    assign bcdAdj = addThree(bcdReg);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (START) nextState = CONVERT;
            CONVERT: if (iterCount == ITER_LAST) nextState = ENCODE;
            ENCODE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A carry out of the thousands nibble only happens for values above 9999,
    // so folding it into the overflow latch is harmless and keeps bit 15 used.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shiftReg   <= '0;
            bcdReg     <= '0;
            iterCount  <= '0;
            dpLatch    <= '0;
            ovfLatch   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            OVERFLOW   <= 1'b0;
            digitOne   <= 8'hFF;
            digitTwo   <= 8'hFF;
            digitThree <= 8'hFF;
            digitFour  <= 8'hFF;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        shiftReg  <= VALUE;
                        bcdReg    <= '0;
                        iterCount <= '0;
                        dpLatch   <= DP_SEL;
                        ovfLatch  <= (32'(VALUE) > MAX_DISPLAY);
                        BUSY      <= 1'b1;
                    end
                end
                CONVERT: begin
                    bcdReg    <= {bcdAdj[14:0], shiftReg[WIDTH-1]};
                    shiftReg  <= shiftReg << 1;
                    iterCount <= iterCount + 5'd1;
                    ovfLatch  <= ovfLatch | bcdAdj[15];
                end
                ENCODE: begin
                    digitOne   <= byteOne;
                    digitTwo   <= byteTwo;
                    digitThree <= byteThree;
                    digitFour  <= byteFour;
                    OVERFLOW   <= ovfLatch;
                    DONE       <= 1'b1;
                    BUSY       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blankOne   = (bcdReg[15:12] == 4'd0);
    assign blankTwo   = blankOne && (bcdReg[11:8] == 4'd0);
    assign blankThree = blankTwo && (bcdReg[7:4] == 4'd0);
`else
    assign blankOne   = 1'b0;
    assign blankTwo   = 1'b0;
    assign blankThree = 1'b0;
`endif

    seg7_encode encOne   (.bcd(bcdReg[15:12]), .blank(blankOne),   .seg(segOne));
    seg7_encode encTwo   (.bcd(bcdReg[11:8]),  .blank(blankTwo),   .seg(segTwo));
    seg7_encode encThree (.bcd(bcdReg[7:4]),   .blank(blankThree), .seg(segThree));
    seg7_encode encFour  (.bcd(bcdReg[3:0]),   .blank(1'b0),       .seg(segFour));

    // Overflow overrides every digit with a dash; DP bits are independent.
    always_comb begin
        byteOne   = {(dpLatch[3] ? 1'b0 : DP_OFF), (ovfLatch ? SEG_DASH : segOne)};
        byteTwo   = {(dpLatch[2] ? 1'b0 : DP_OFF), (ovfLatch ? SEG_DASH : segTwo)};
        byteThree = {(dpLatch[1] ? 1'b0 : DP_OFF), (ovfLatch ? SEG_DASH : segThree)};
        byteFour  = {(dpLatch[0] ? 1'b0 : DP_OFF), (ovfLatch ? SEG_DASH : segFour)};
    end

endmodule

// File: tb/tb_bin_to_seg_formatter.sv
// Scoreboard bench for bin_to_seg_formatter: stimulus pushes expected bytes,
// a DONE-driven monitor pops and compares them.
module tb_bin_to_seg_formatter;

    localparam int WIDTH = 14;
    localparam int LATENCY = 15;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [WIDTH-1:0] VALUE;
    logic [3:0]       DP_SEL;
    logic             BUSY;
    logic             DONE;
    logic             OVERFLOW;
    logic [7:0]       digitOne;
    logic [7:0]       digitTwo;
    logic [7:0]       digitThree;
    logic [7:0]       digitFour;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        logic [7:0] d4;
        logic       ovf;
        int         acceptCycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks    = 0;
    int   errors    = 0;
    int   cycleCnt  = 0;
    int   doneCount = 0;
    int   doneMark;

    bin_to_seg_formatter #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST(RST), .START(START), .VALUE(VALUE), .DP_SEL(DP_SEL),
        .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW),
        .digitOne(digitOne), .digitTwo(digitTwo),
        .digitThree(digitThree), .digitFour(digitFour)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0 && DONE === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got DONE=1, expected no pulse at cycle %0d", cycleCnt);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("digitOne",   32'(digitOne),   32'(monExp.d1));
                checkOutput("digitTwo",   32'(digitTwo),   32'(monExp.d2));
                checkOutput("digitThree", 32'(digitThree), 32'(monExp.d3));
                checkOutput("digitFour",  32'(digitFour),  32'(monExp.d4));
                checkOutput("overflow",   32'(OVERFLOW),   32'(monExp.ovf));
                checkOutput("latency",    32'(cycleCnt - monExp.acceptCycle), 32'(LATENCY));
                checkOutput("busyAtDone", 32'(BUSY), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] value, input logic [3:0] dp,
                                 input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [7:0] d3, input logic [7:0] d4,
                                 input logic ovf);
        exp_t e;
        int guard = 0;
        @(negedge CLK);
        while (BUSY !== 1'b0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL idleTimeout: got BUSY=%0b, expected 0 within 100 cycles", BUSY);
        end
        VALUE  = value;
        DP_SEL = dp;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        e.d1 = d1;
        e.d2 = d2;
        e.d3 = d3;
        e.d4 = d4;
        e.ovf = ovf;
        e.acceptCycle = cycleCnt;
        expQ.push_back(e);
        checkOutput("busyAfterAccept", 32'(BUSY), 32'd1);
    endtask

    task automatic waitIdle();
        int guard = 0;
        @(negedge CLK);
        while ((BUSY !== 1'b0 || expQ.size() != 0) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: got %0d pending results, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST    = 1'b1;
        START  = 1'b0;
        VALUE  = '0;
        DP_SEL = 4'b0000;
        repeat (3) @(negedge CLK);
        checkOutput("resetDigitOne",   32'(digitOne),   32'hFF);
        checkOutput("resetDigitFour",  32'(digitFour),  32'hFF);
        checkOutput("resetBusy",       32'(BUSY),       32'd0);
        checkOutput("resetDone",       32'(DONE),       32'd0);
        checkOutput("resetOverflow",   32'(OVERFLOW),   32'd0);
        RST = 1'b0;

        applyStimulus(14'd1234, 4'b0000, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);
        waitIdle();
        applyStimulus(14'd5678, 4'b0100, 8'h92, 8'h02, 8'hF8, 8'h80, 1'b0);
        waitIdle();
        applyStimulus(14'd12000, 4'b0000, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 1'b1);
        waitIdle();
        applyStimulus(14'd9999, 4'b0000, 8'h90, 8'h90, 8'h90, 8'h90, 1'b0);
        waitIdle();
`ifdef LEADING_ZERO_BLANK_EN
        applyStimulus(14'd7, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 1'b0);
        waitIdle();
        applyStimulus(14'd0, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 1'b0);
        waitIdle();
        applyStimulus(14'd40, 4'b1000, 8'h7F, 8'hFF, 8'h99, 8'hC0, 1'b0);
        waitIdle();
`else
        applyStimulus(14'd7, 4'b0000, 8'hC0, 8'hC0, 8'hC0, 8'hF8, 1'b0);
        waitIdle();
        applyStimulus(14'd0, 4'b0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);
        waitIdle();
        applyStimulus(14'd40, 4'b1000, 8'h40, 8'hC0, 8'h99, 8'hC0, 1'b0);
        waitIdle();
`endif
        applyStimulus(14'd12000, 4'b1010, 8'h3F, 8'hBF, 8'h3F, 8'hBF, 1'b1);
        waitIdle();
        applyStimulus(14'd16383, 4'b0000, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 1'b1);
        waitIdle();

        // A second START mid-conversion must be dropped without queueing.
        doneMark = doneCount;
        applyStimulus(14'd2468, 4'b0001, 8'hA4, 8'h99, 8'h82, 8'h00, 1'b0);
        repeat (5) @(negedge CLK);
        VALUE  = 14'd1111;
        DP_SEL = 4'b1111;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        waitIdle();
        repeat (20) @(negedge CLK);
        checkOutput("singleDonePulse", 32'(doneCount - doneMark), 32'd1);

        // Reset part-way through a conversion blanks outputs with no DONE.
        @(negedge CLK);
        VALUE  = 14'd8888;
        DP_SEL = 4'b0000;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        doneMark = doneCount;
        repeat (6) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("midResetBusy",       32'(BUSY),       32'd0);
        checkOutput("midResetDigitOne",   32'(digitOne),   32'hFF);
        checkOutput("midResetDigitTwo",   32'(digitTwo),   32'hFF);
        checkOutput("midResetDigitThree", 32'(digitThree), 32'hFF);
        checkOutput("midResetDigitFour",  32'(digitFour),  32'hFF);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (25) @(negedge CLK);
        checkOutput("noDoneAfterReset", 32'(doneCount - doneMark), 32'd0);

        applyStimulus(14'd1234, 4'b0000, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
